// File: rtl/bulls_cows_core.sv
// Bulls-and-cows game core: secret entry, guess scoring, win/lose sequencing.
// Button pulses are pre-debounced; tick is a slow timebase used only in CORRECT.
module bulls_cows_core #(
  parameter int NDIG      = 4,
  parameter int DMAX      = 9,
  parameter int MAX_TRY   = 8,
  parameter int WIN_TICKS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_r,
  input  logic                 btn_l,
  input  logic                 btn_u,
  input  logic                 btn_d,
  input  logic                 tick,
  output logic [4*NDIG-1:0]    disp_code,
  output logic [NDIG-1:0]      cursor,
  output logic [2:0]           state,
  output logic [3:0]           try_cnt,
  output logic [3:0]           bulls,
  output logic [3:0]           cows,
  output logic                 win,
  output logic                 lose,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET     = 3'd1,
    S_GUESS   = 3'd2,
    S_WRONG   = 3'd3,
    S_CORRECT = 3'd4,
    S_LOSE    = 3'd5
  } state_t;

  localparam int TW = (WIN_TICKS > 1) ? $clog2(WIN_TICKS) : 1;
  localparam logic [NDIG-1:0] CUR_MSB = {1'b1, {(NDIG-1){1'b0}}};

  state_t state_q, state_nxt;

  logic [NDIG-1:0][3:0] dig_q, secret_q, disp_c;
  logic [NDIG-1:0]      cur_q;
  logic [3:0]           try_q, bulls_q, cows_q, bulls_c, cows_c;
  logic [TW-1:0]        tick_q;
  logic                 err_q, dup_c, hit;

  logic pr, pl, pu, pd;
  logic clr_edit, start, shift, inc, dec, set_ok, set_dup, score, tick_adv;

  // One action per cycle: r > l > u > d
  assign pr = btn_r;
  assign pl = !btn_r && btn_l;
  assign pu = !btn_r && !btn_l && btn_u;
  assign pd = !btn_r && !btn_l && !btn_u && btn_d;

  always_comb begin
    dup_c = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++)
      for (int unsigned j = i + 1; j < NDIG; j++)
        if (dig_q[i] == dig_q[j]) dup_c = 1'b1;
  end

  // Cows count each guess position once, even if the guess repeats a digit
  always_comb begin
    bulls_c = '0;
    cows_c  = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      hit = 1'b0;
      for (int unsigned j = 0; j < NDIG; j++)
        if (j != i && dig_q[i] == secret_q[j]) hit = 1'b1;
      if (dig_q[i] == secret_q[i]) bulls_c = bulls_c + 4'd1;
      if (hit) cows_c = cows_c + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    clr_edit  = 1'b0;
    start     = 1'b0;
    shift     = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;
    set_ok    = 1'b0;
    set_dup   = 1'b0;
    score     = 1'b0;
    tick_adv  = 1'b0;
    case (state_q)
      S_IDLE: if (pr) begin
        state_nxt = S_SET;
        clr_edit  = 1'b1;
        start     = 1'b1;
      end
      S_SET, S_GUESS: begin
        if (pr) begin
          if (!cur_q[0]) begin
            shift = 1'b1;
          end else if (state_q == S_SET) begin
            if (dup_c) begin
              set_dup = 1'b1;
            end else begin
              set_ok    = 1'b1;
              clr_edit  = 1'b1;
              state_nxt = S_GUESS;
            end
          end else begin
            score = 1'b1;
            if (bulls_c == 4'(NDIG))                   state_nxt = S_CORRECT;
            else if ((try_q + 4'd1) == 4'(MAX_TRY))    state_nxt = S_LOSE;
            else                                       state_nxt = S_WRONG;
          end
        end else if (pl) begin
          state_nxt = S_IDLE;
        end else if (pu) begin
          inc = 1'b1;
        end else if (pd) begin
          dec = 1'b1;
        end
      end
      S_WRONG: begin
        if (pr) begin
          state_nxt = S_GUESS;
          clr_edit  = 1'b1;
        end else if (pl) begin
          state_nxt = S_IDLE;
        end
      end
      S_CORRECT: if (tick) begin
        if (tick_q == TW'(WIN_TICKS - 1)) state_nxt = S_IDLE;
        else                              tick_adv  = 1'b1;
      end
      S_LOSE: if (btn_r || btn_l) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NDIG; i++) dig_q[i] <= 4'd12;
      secret_q <= '0;
      cur_q    <= '0;
      try_q    <= '0;
      bulls_q  <= '0;
      cows_q   <= '0;
      tick_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= set_dup;
      if (clr_edit) begin
        dig_q <= '0;
        cur_q <= CUR_MSB;
      end
      if (start)   try_q    <= '0;
      if (set_ok)  secret_q <= dig_q;
      if (shift)   cur_q    <= cur_q >> 1;
      if (set_dup) cur_q    <= CUR_MSB;
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (cur_q[i] && inc && dig_q[i] < 4'(DMAX)) dig_q[i] <= dig_q[i] + 4'd1;
        if (cur_q[i] && dec && dig_q[i] != 4'd0)    dig_q[i] <= dig_q[i] - 4'd1;
      end
      if (score) begin
        try_q   <= try_q + 4'd1;
        bulls_q <= bulls_c;
        cows_q  <= cows_c;
        tick_q  <= '0;
      end
      if (tick_adv) tick_q <= tick_q + 1'b1;
      if (state_nxt == S_IDLE) begin
        bulls_q <= '0;
        cows_q  <= '0;
        tick_q  <= '0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NDIG; i++) disp_c[i] = 4'd12;
    case (state_q)
      S_SET, S_GUESS, S_CORRECT: disp_c = dig_q;
      S_WRONG: begin
        disp_c[NDIG-1] = bulls_q;
        disp_c[NDIG-2] = 4'd10;
        disp_c[NDIG-3] = cows_q;
        disp_c[NDIG-4] = 4'd11;
      end
      S_LOSE:  disp_c = secret_q;
      default: ;
    endcase
  end

  assign disp_code = disp_c;
  assign cursor    = (state_q == S_SET || state_q == S_GUESS) ? cur_q : '0;
  assign state     = state_q;
  assign try_cnt   = try_q;
  assign bulls     = bulls_q;
  assign cows      = cows_q;
  assign win       = (state_q == S_CORRECT);
  assign lose      = (state_q == S_LOSE);
  assign err       = err_q;

endmodule

// File: tb/tb_bulls_cows_core.sv
// Directed bench for bulls_cows_core: single-cycle vector table plus whole-game sequences.
module tb_bulls_cows_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_r = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0, tick = 1'b0;
  logic [15:0] disp_code;
  logic [3:0]  cursor;
  logic [2:0]  state;
  logic [3:0]  try_cnt, bulls, cows;
  logic        win, lose, err;

  int n_chk  = 0;
  int n_fail = 0;

  bulls_cows_core #(.NDIG(4), .DMAX(9), .MAX_TRY(2), .WIN_TICKS(5)) dut (
    .clk(clk), .rst(rst),
    .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d), .tick(tick),
    .disp_code(disp_code), .cursor(cursor), .state(state), .try_cnt(try_cnt),
    .bulls(bulls), .cows(cows), .win(win), .lose(lose), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  btn;   // {r,l,u,d}
    logic        tk;
    logic [2:0]  st;
    logic [15:0] disp;
    logic [3:0]  cur;
    logic        er;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic t);
    @(negedge clk);
    {btn_r, btn_l, btn_u, btn_d} = b;
    tick = t;
    @(posedge clk);
    #1;
    {btn_r, btn_l, btn_u, btn_d} = 4'b0000;
    tick = 1'b0;
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    logic [3:0] v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < int'(v[k]); n++) step(4'b0010, 1'b0);
      step(4'b1000, 1'b0);
    end
  endtask

  task automatic check_sdc(input string nm, input logic [2:0] st, input logic [15:0] dsp, input logic [3:0] cur);
    check({nm, ".state"}, 32'(state), 32'(st));
    check({nm, ".disp"}, 32'(disp_code), 32'(dsp));
    check({nm, ".cursor"}, 32'(cursor), 32'(cur));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0000, 1'b0, 3'd0, 16'hCCCC, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1000, 1'b0, 3'd1, 16'h0000, 4'b1000, 1'b0};
    tbl[2]  = '{4'b0010, 1'b0, 3'd1, 16'h1000, 4'b1000, 1'b0};
    tbl[3]  = '{4'b0011, 1'b0, 3'd1, 16'h2000, 4'b1000, 1'b0};
    tbl[4]  = '{4'b0001, 1'b0, 3'd1, 16'h1000, 4'b1000, 1'b0};
    tbl[5]  = '{4'b0001, 1'b0, 3'd1, 16'h0000, 4'b1000, 1'b0};
    tbl[6]  = '{4'b0001, 1'b0, 3'd1, 16'h0000, 4'b1000, 1'b0};
    tbl[7]  = '{4'b1100, 1'b0, 3'd1, 16'h0000, 4'b0100, 1'b0};
    tbl[8]  = '{4'b0010, 1'b0, 3'd1, 16'h0100, 4'b0100, 1'b0};
    tbl[9]  = '{4'b0100, 1'b0, 3'd0, 16'hCCCC, 4'b0000, 1'b0};
    tbl[10] = '{4'b1000, 1'b0, 3'd1, 16'h0000, 4'b1000, 1'b0};
    tbl[11] = '{4'b1000, 1'b0, 3'd1, 16'h0000, 4'b0100, 1'b0};
    tbl[12] = '{4'b1000, 1'b0, 3'd1, 16'h0000, 4'b0010, 1'b0};
    tbl[13] = '{4'b1000, 1'b0, 3'd1, 16'h0000, 4'b0001, 1'b0};
    tbl[14] = '{4'b1000, 1'b0, 3'd1, 16'h0000, 4'b1000, 1'b1};
    tbl[15] = '{4'b0000, 1'b0, 3'd1, 16'h0000, 4'b1000, 1'b0};
    tbl[16] = '{4'b0100, 1'b0, 3'd0, 16'hCCCC, 4'b0000, 1'b0};

    // Reset values before any clock edge
    #2;
    check_sdc("rst0", 3'd0, 16'hCCCC, 4'b0000);
    check("rst0.try", 32'(try_cnt), 0);
    check("rst0.bulls", 32'(bulls), 0);
    check("rst0.cows", 32'(cows), 0);
    check("rst0.wle", 32'({win, lose, err}), 0);
    #10 rst = 1'b0;

    for (int r = 0; r < 17; r++) begin
      step(tbl[r].btn, tbl[r].tk);
      check_sdc($sformatf("vec%0d", r), tbl[r].st, tbl[r].disp, tbl[r].cur);
      check($sformatf("vec%0d.err", r), 32'(err), 32'(tbl[r].er));
    end

    // Digit saturation
    step(4'b1000, 1'b0);
    repeat (12) step(4'b0010, 1'b0);
    check("sat_up.disp", 32'(disp_code), 32'h9000);
    repeat (12) step(4'b0001, 1'b0);
    check("sat_dn.disp", 32'(disp_code), 32'h0000);
    step(4'b0100, 1'b0);

    // Duplicate secret rejected
    step(4'b1000, 1'b0);
    enter(4'd1, 4'd1, 4'd2, 4'd3);
    check_sdc("dup", 3'd1, 16'h1123, 4'b1000);
    check("dup.err", 32'(err), 1);
    step(4'b0000, 1'b0);
    check("dup.err_clr", 32'(err), 0);
    check("dup.state2", 32'(state), 1);
    step(4'b0100, 1'b0);

    // Secret 1234, guess 1243 -> WRONG 2 bulls 2 cows
    step(4'b1000, 1'b0);
    enter(4'd1, 4'd2, 4'd3, 4'd4);
    check_sdc("sec", 3'd2, 16'h0000, 4'b1000);
    check("sec.try", 32'(try_cnt), 0);
    enter(4'd1, 4'd2, 4'd4, 4'd3);
    check_sdc("wrong", 3'd3, 16'h2A2B, 4'b0000);
    check("wrong.bulls", 32'(bulls), 2);
    check("wrong.cows", 32'(cows), 2);
    check("wrong.try", 32'(try_cnt), 1);
    check("wrong.wl", 32'({win, lose}), 0);
    step(4'b1000, 1'b0);
    check_sdc("reguess", 3'd2, 16'h0000, 4'b1000);
    check("reguess.bulls", 32'(bulls), 2);

    // Correct guess on the last allowed try wins, then times out after 5 ticks
    enter(4'd1, 4'd2, 4'd3, 4'd4);
    check_sdc("win", 3'd4, 16'h1234, 4'b0000);
    check("win.win", 32'(win), 1);
    check("win.bulls", 32'(bulls), 4);
    check("win.cows", 32'(cows), 0);
    check("win.try", 32'(try_cnt), 2);
    step(4'b0100, 1'b0);
    check("win.ignore_btn", 32'(state), 4);
    for (int t = 1; t <= 5; t++) begin
      step(4'b0000, 1'b1);
      check($sformatf("win.tick%0d", t), 32'(state), (t == 5) ? 0 : 4);
      step(4'b0000, 1'b0);
    end
    check("win.idle_disp", 32'(disp_code), 32'hCCCC);
    check("win.idle_bc", 32'({bulls, cows}), 0);
    check("win.idle_win", 32'(win), 0);

    // Two wrong guesses with MAX_TRY=2 -> LOSE showing the secret
    step(4'b1000, 1'b0);
    check("lose.try_clr", 32'(try_cnt), 0);
    enter(4'd5, 4'd6, 4'd7, 4'd8);
    enter(4'd1, 4'd2, 4'd3, 4'd4);
    check_sdc("lose.g1", 3'd3, 16'h0A0B, 4'b0000);
    check("lose.g1.try", 32'(try_cnt), 1);
    step(4'b1000, 1'b0);
    enter(4'd8, 4'd7, 4'd6, 4'd5);
    check_sdc("lose", 3'd5, 16'h5678, 4'b0000);
    check("lose.lose", 32'(lose), 1);
    check("lose.cows", 32'(cows), 4);
    check("lose.try", 32'(try_cnt), 2);
    step(4'b0100, 1'b0);
    check_sdc("lose.exit", 3'd0, 16'hCCCC, 4'b0000);
    check("lose.lose_clr", 32'(lose), 0);

    // Asynchronous reset in GUESS
    step(4'b1000, 1'b0);
    enter(4'd1, 4'd2, 4'd3, 4'd4);
    enter(4'd1, 4'd2, 4'd4, 4'd3);
    step(4'b1000, 1'b0);
    step(4'b0010, 1'b0);
    check("arst.pre", 32'(disp_code), 32'h1000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_sdc("arst", 3'd0, 16'hCCCC, 4'b0000);
    check("arst.try", 32'(try_cnt), 0);
    check("arst.bc", 32'({bulls, cows}), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(4'b1000, 1'b0);
    check_sdc("arst.set", 3'd1, 16'h0000, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bulls_cows_core.md
BULLS_COWS_CORE -- requirements
Module: bulls_cows_core

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning digits per code (legal 4..8).
REQ-002 SHALL have parameter DMAX, default 9, meaning largest digit value (legal 1..9).
REQ-003 SHALL have parameter MAX_TRY, default 8, meaning guesses allowed before loss (legal 1..15).
REQ-004 SHALL have parameter WIN_TICKS, default 5, meaning tick pulses spent in CORRECT.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have ports btn_r, btn_l, btn_u, btn_d, input, 1 each, meaning single-cycle, already debounced button pulses.
REQ-008 SHALL have port tick, input, 1, meaning a single-cycle timebase pulse (nominally 1 Hz).
REQ-009 SHALL have port disp_code, output, 4*NDIG, meaning per-position display code (0..9 digit, 10 'A', 11 'b', 12 dash); position NDIG-1 in the MSBs.
REQ-010 SHALL have port cursor, output, NDIG, meaning one-hot edit position, or all-zero when not editing.
REQ-011 SHALL have port state, output, 3, meaning the current state code.
REQ-012 SHALL have port try_cnt, output, 4, meaning guesses committed since SET.
REQ-013 SHALL have ports bulls and cows, output, 4 each, meaning the last guess score.
REQ-014 SHALL have ports win and lose, output, 1 each, meaning high while in CORRECT or LOSE respectively.
REQ-015 SHALL have port err, output, 1, meaning a one-cycle pulse on a rejected secret.

Function
REQ-016 SHALL implement states IDLE=0, SET=1, GUESS=2, WRONG=3, CORRECT=4, LOSE=5; codes 6 and 7 return to IDLE on the next cycle.
REQ-017 SHALL, when several buttons pulse in one cycle, act on the highest priority only: btn_r > btn_l > btn_u > btn_d.
REQ-018 SHALL drive, in IDLE, all disp_code digits to 12 and cursor to 0; btn_r → SET with all digits 0, cursor at bit NDIG-1, and try_cnt cleared.
REQ-019 SHALL, in SET/GUESS, make btn_u increment the cursor digit saturating at DMAX, and btn_d decrement it saturating at 0.
REQ-020 SHALL, in SET/GUESS, make btn_r with cursor≠bit0 shift cursor right by one (no commit), and btn_l go to IDLE.
REQ-021 SHALL, on SET btn_r with cursor at bit0 (commit), latch the digits as the secret and enter GUESS with digits 0 and cursor at MSB, if all secret digits are distinct.
REQ-022 SHALL, on a SET commit with duplicate digits, pulse err for 1 cycle, stay in SET, keep the digits, and return cursor to MSB.
REQ-023 SHALL, on a GUESS commit, compute bulls = count of positions i with guess[i]==secret[i].
REQ-024 SHALL, on a GUESS commit, compute cows = count of positions i with guess[i]==secret[j] for some j≠i.
REQ-025 SHALL, on a GUESS commit, increment try_cnt and register bulls/cows in the same edge; latency 1 cycle.
REQ-026 SHALL transition after a GUESS commit: bulls==NDIG → CORRECT; else new try_cnt==MAX_TRY → LOSE; else WRONG.
REQ-027 SHALL, in WRONG, display bulls at position NDIG-1, 10 at NDIG-2, cows at NDIG-3, 11 at NDIG-4, and 12 elsewhere; cursor 0.
REQ-028 SHALL, in WRONG, make btn_r go to GUESS with digits 0 and cursor at MSB, and btn_l go to IDLE.
REQ-029 SHALL, in CORRECT, show the guess, count tick pulses, and enter IDLE on the WIN_TICKS-th tick; buttons are ignored.
REQ-030 SHALL, in LOSE, show the secret, and make btn_r or btn_l go to IDLE.
REQ-031 SHALL hold bulls/cows until the next GUESS commit or entry to IDLE (cleared to 0).
REQ-032 SHALL compute bulls/cows at 4-bit width (max 8, no overflow); try_cnt SHALL not wrap because LOSE precedes it.

Reset
REQ-033 SHALL, while rst=1 and regardless of clk, force state=IDLE, every digit=12, secret=0, cursor=0, and try_cnt/bulls/cows/tick counter=0.
REQ-034 SHALL, while rst=1 and regardless of clk, force win=lose=err=0.
REQ-035 SHALL, on rst asserted mid-game in any state, abandon the game and apply the REQ-033/REQ-034 values; the first post-reset edge behaves as IDLE.

Verification
REQ-036 SHALL cover, at NDIG=4: set secret 1234, guess 1243 → WRONG, bulls=2, cows=2, disp_code={2,10,2,11}, try_cnt=1.
REQ-037 SHALL cover: secret 1234, guess 1234 → CORRECT, win=1; after exactly 5 ticks → IDLE, disp all 12.
REQ-038 SHALL cover: secret 1123 committed → err one cycle, state stays SET, digits 1123 retained, cursor=4'b1000.
REQ-039 SHALL cover: btn_u ×12 on a digit → value 9; btn_d ×12 → value 0; btn_u and btn_d in the same cycle → btn_u applied.
REQ-040 SHALL cover: MAX_TRY=2 with two wrong guesses → LOSE, lose=1, disp shows the secret; btn_l → IDLE.
REQ-041 SHALL cover: rst pulsed asynchronously (not clock-aligned) during GUESS → immediate IDLE values; btn_r then → SET.
